// File: rtl/counter_pair_ctrl_pkg.sv
// Shared types and reset defaults for the counter pair controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } state_t;

  localparam int DEF_INIT1 = 0;
  localparam int DEF_INIT2 = 2;
  localparam int DEF_LIMIT = 10;

endpackage

// File: rtl/counter_pair_ctrl_if.sv
// Bundles the config handshake, run controls and status of counter_pair_ctrl.
// Latency: n/a (wires only).
// Backpressure: cfg_valid is held by the master until cfg_ready (IDLE only).
interface counter_pair_ctrl_if #(
  parameter int SIZE = 8,
  parameter int RCW  = 8
);
  logic            cfg_valid;
  logic            cfg_ready;
  logic [SIZE-1:0] cfg_init1;
  logic [SIZE-1:0] cfg_init2;
  logic [SIZE-1:0] cfg_limit;
  logic            start;
  logic            stop;
  logic            busy;
  logic [SIZE-1:0] cnt1;
  logic [SIZE-1:0] cnt2;
  logic [SIZE-1:0] sum;
  logic            reload_pulse;
  logic [RCW-1:0]  reload_count;

  // Controller side: takes config and run requests, reports status.
  modport slave (
    input  cfg_valid, cfg_init1, cfg_init2, cfg_limit, start, stop,
    output cfg_ready, busy, cnt1, cnt2, sum, reload_pulse, reload_count
  );

  // Host side: offers config and run requests, observes status.
  modport master (
    output cfg_valid, cfg_init1, cfg_init2, cfg_limit, start, stop,
    input  cfg_ready, busy, cnt1, cnt2, sum, reload_pulse, reload_count
  );
endinterface

// File: rtl/counter_pair_ctrl_step.sv
// SIZE-wide counter register with load and increment enables; load wins.
// Latency: 1 cycle from enable to new value.
// Backpressure: none; enables are obeyed every cycle.
module ctr_step #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            inc,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_d;
  logic [SIZE-1:0] q_q;

  // Next value: load has priority over increment; increment wraps.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (inc) begin
      q_d = q_q + SIZE'(1);
    end
  end

  // Counter register with asynchronous reset to its default value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_pair_ctrl.sv
// Two alternating counters that reload from init values when their sum passes a limit.
// Latency: counters/status update 1 cycle after the controlling request; sum is combinational.
// Backpressure: config accepted only in IDLE (cfg_ready); start/stop outside their states are ignored.
module counter_pair_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int RCW  = 8
) (
  input  logic                clk,
  input  logic                rst,
  counter_pair_ctrl_if.slave  bus
);

  state_t          state_d, state_q;
  logic            phase_d, phase_q;
  logic [SIZE-1:0] init1_d, init1_q;
  logic [SIZE-1:0] init2_d, init2_q;
  logic [SIZE-1:0] limit_d, limit_q;
  logic [RCW-1:0]  rc_d, rc_q;

  logic            ld1, ld2, inc1, inc2;
  logic [SIZE-1:0] ld1_val, ld2_val;
  logic [SIZE-1:0] cnt1, cnt2, sum;
  logic            cfg_hs;

  assign sum    = cnt1 + cnt2;
  assign cfg_hs = bus.cfg_valid && (state_q == ST_IDLE);

  // Next-state and counter control; stop beats threshold beats increment in RUN.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    init1_d = init1_q;
    init2_d = init2_q;
    limit_d = limit_q;
    rc_d    = rc_q;
    ld1     = 1'b0;
    ld2     = 1'b0;
    ld1_val = init1_q;
    ld2_val = init2_q;
    inc1    = 1'b0;
    inc2    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_hs) begin
          // Config wins over a simultaneous start.
          init1_d = bus.cfg_init1;
          init2_d = bus.cfg_init2;
          limit_d = bus.cfg_limit;
          ld1     = 1'b1;
          ld2     = 1'b1;
          ld1_val = bus.cfg_init1;
          ld2_val = bus.cfg_init2;
        end else if (bus.start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (sum > limit_q) begin
          state_d = ST_RELOAD;
        end else begin
          inc1    = ~phase_q;
          inc2    = phase_q;
          phase_d = ~phase_q;
        end
      end
      ST_RELOAD: begin
        ld1     = 1'b1;
        ld2     = 1'b1;
        phase_d = 1'b0;
        rc_d    = (rc_q == '1) ? rc_q : rc_q + RCW'(1);
        state_d = bus.stop ? ST_IDLE : ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, phase, latched config and reload counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      init1_q <= SIZE'(DEF_INIT1);
      init2_q <= SIZE'(DEF_INIT2);
      limit_q <= SIZE'(DEF_LIMIT);
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      init1_q <= init1_d;
      init2_q <= init2_d;
      limit_q <= limit_d;
      rc_q    <= rc_d;
    end
  end

  ctr_step #(
    .SIZE    (SIZE),
    .RST_VAL (SIZE'(DEF_INIT1))
  ) u_ctr1 (
    .clk      (clk),
    .rst      (rst),
    .load     (ld1),
    .load_val (ld1_val),
    .inc      (inc1),
    .q        (cnt1)
  );

  ctr_step #(
    .SIZE    (SIZE),
    .RST_VAL (SIZE'(DEF_INIT2))
  ) u_ctr2 (
    .clk      (clk),
    .rst      (rst),
    .load     (ld2),
    .load_val (ld2_val),
    .inc      (inc2),
    .q        (cnt2)
  );

  assign bus.cfg_ready    = (state_q == ST_IDLE);
  assign bus.busy         = (state_q == ST_RUN) || (state_q == ST_RELOAD);
  assign bus.reload_pulse = (state_q == ST_RELOAD);
  assign bus.reload_count = rc_q;
  assign bus.cnt1         = cnt1;
  assign bus.cnt2         = cnt2;
  assign bus.sum          = sum;

endmodule

// File: tb/tb_counter_pair_ctrl.sv
// Directed bench for counter_pair_ctrl with hand-computed expectations.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: config offered only where the test intends acceptance or refusal.
module tb_counter_pair_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  counter_pair_ctrl_if #(.SIZE(8), .RCW(8)) bus ();

  counter_pair_ctrl #(.SIZE(8), .RCW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One rising edge, then return on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cfg(input logic [7:0] i1, input logic [7:0] i2, input logic [7:0] lim);
    bus.cfg_valid = 1'b1;
    bus.cfg_init1 = i1;
    bus.cfg_init2 = i2;
    bus.cfg_limit = lim;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_init1 = '0;
    bus.cfg_init2 = '0;
    bus.cfg_limit = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_cnt1", bus.cnt1, 0);
    chk("rst_cnt2", bus.cnt2, 2);
    chk("rst_sum", bus.sum, 2);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulse", bus.reload_pulse, 0);
    chk("rst_rc", bus.reload_count, 0);
    rst = 1'b0;
    tick();

    // Default run: sums 3..11, detect, reload
    pulse_start();
    chk("run_busy", bus.busy, 1);
    chk("run_cfg_ready", bus.cfg_ready, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("run_sum%0d", k), bus.sum, 2 + k);
      chk($sformatf("run_nopulse%0d", k), bus.reload_pulse, 0);
    end
    tick();
    chk("detect_pulse", bus.reload_pulse, 1);
    chk("detect_cnt1", bus.cnt1, 5);
    chk("detect_cnt2", bus.cnt2, 6);
    tick();
    chk("reload_cnt1", bus.cnt1, 0);
    chk("reload_cnt2", bus.cnt2, 2);
    chk("reload_rc", bus.reload_count, 1);
    chk("reload_pulse_off", bus.reload_pulse, 0);
    chk("reload_busy", bus.busy, 1);
    pulse_stop();
    chk("stop_busy", bus.busy, 0);
    chk("stop_cnt1", bus.cnt1, 0);
    chk("stop_cnt2", bus.cnt2, 2);

    // Config accepted in IDLE, refused in RUN
    cfg(8'd5, 8'd5, 8'd12);
    chk("cfg_cnt1", bus.cnt1, 5);
    chk("cfg_cnt2", bus.cnt2, 5);
    chk("cfg_sum", bus.sum, 10);
    chk("cfg_busy", bus.busy, 0);
    pulse_start();
    tick();
    chk("cfg_run_cnt1", bus.cnt1, 6);
    bus.cfg_valid = 1'b1;
    bus.cfg_init1 = 8'd100;
    bus.cfg_init2 = 8'd100;
    bus.cfg_limit = 8'd200;
    chk("cfg_run_ready", bus.cfg_ready, 0);
    tick();
    bus.cfg_valid = 1'b0;
    chk("cfg_run_cnt1b", bus.cnt1, 6);
    chk("cfg_run_cnt2b", bus.cnt2, 6);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("cfg_run_sum13", bus.sum, 13);
    tick();
    chk("cfg_detect_pulse", bus.reload_pulse, 1);
    tick();
    chk("cfg_reload_cnt1", bus.cnt1, 5);
    chk("cfg_reload_cnt2", bus.cnt2, 5);
    chk("cfg_reload_rc", bus.reload_count, 2);
    pulse_stop();

    // Stop on the detect cycle beats the reload
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_rc", bus.reload_count, 0);
    pulse_start();
    ticks(9);
    chk("stopdet_sum", bus.sum, 11);
    pulse_stop();
    chk("stopdet_busy", bus.busy, 0);
    chk("stopdet_pulse", bus.reload_pulse, 0);
    chk("stopdet_cnt1", bus.cnt1, 5);
    chk("stopdet_cnt2", bus.cnt2, 6);
    chk("stopdet_rc", bus.reload_count, 0);

    // Stop during RELOAD: reload completes, then IDLE
    pulse_start();
    tick();
    chk("stoprl_pulse", bus.reload_pulse, 1);
    pulse_stop();
    chk("stoprl_busy", bus.busy, 0);
    chk("stoprl_cnt1", bus.cnt1, 0);
    chk("stoprl_cnt2", bus.cnt2, 2);
    chk("stoprl_rc", bus.reload_count, 1);

    // Config together with start: config taken, start ignored
    bus.start = 1'b1;
    cfg(8'd254, 8'd0, 8'd255);
    bus.start = 1'b0;
    chk("cfgstart_busy", bus.busy, 0);
    chk("cfgstart_cnt1", bus.cnt1, 254);
    chk("cfgstart_cnt2", bus.cnt2, 0);
    pulse_stop();
    chk("idlestop_ready", bus.cfg_ready, 1);

    // Wrap with limit at all-ones: no reload
    pulse_start();
    tick();
    chk("wrap_cnt1_255", bus.cnt1, 255);
    chk("wrap_sum255", bus.sum, 255);
    tick();
    chk("wrap_sum0", bus.sum, 0);
    chk("wrap_cnt2_1", bus.cnt2, 1);
    tick();
    chk("wrap_cnt1_0", bus.cnt1, 0);
    chk("wrap_sum1", bus.sum, 1);
    chk("wrap_pulse", bus.reload_pulse, 0);
    chk("wrap_rc", bus.reload_count, 1);
    pulse_stop();

    // Asynchronous reset in the middle of RELOAD
    cfg(8'd5, 8'd6, 8'd10);
    pulse_start();
    tick();
    chk("arst_pre_pulse", bus.reload_pulse, 1);
    chk("arst_pre_rc", bus.reload_count, 1);
    rst = 1'b1;
    #1;
    chk("arst_ready", bus.cfg_ready, 1);
    chk("arst_busy", bus.busy, 0);
    chk("arst_pulse", bus.reload_pulse, 0);
    chk("arst_rc", bus.reload_count, 0);
    chk("arst_cnt1", bus.cnt1, 0);
    chk("arst_cnt2", bus.cnt2, 2);
    chk("arst_sum", bus.sum, 2);
    tick();
    chk("arst_hold_busy", bus.busy, 0);
    chk("arst_hold_rc", bus.reload_count, 0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
